// File: rtl/ddr2_wr_blk_packer_72b_to_288b.sv
// Packs 72-bit words into 288-bit blocks for the DDR2 block-transfer FIFO write port.
// Packet ends are padded to a whole block; one output register absorbs FIFO backpressure.
module ddr2_wr_blk_packer_72b_to_288b #(
    parameter logic [71:0] PAD_WORD      = 72'h0,
    parameter int unsigned BLK_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [71:0]              in_data,
    input  logic                     in_eop,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [287:0]             out_data,
    output logic                     out_wr_en,
    input  logic                     out_full,
    output logic [BLK_CNT_WIDTH-1:0] blk_cnt,
    output logic [1:0]               slot_cnt
);

    logic [215:0] acc;
    logic         pending;
    logic         accept;
    logic         close;
    logic [287:0] blk;
    logic [287:0] base;

    assign in_ready  = ~pending | ~out_full;
    assign out_wr_en = pending & ~out_full;
    assign accept    = in_valid & in_ready;
    assign close     = accept & ((slot_cnt == 2'd3) | in_eop);
    assign base      = {acc, PAD_WORD};

    // Slots below slot_cnt come from the accumulator, the incoming word takes
    // slot slot_cnt, and everything after it is padding.
    always_comb begin
        blk = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < {30'd0, slot_cnt})
                blk[287-72*k -: 72] = base[287-72*k -: 72];
            else if (k == {30'd0, slot_cnt})
                blk[287-72*k -: 72] = in_data;
            else
                blk[287-72*k -: 72] = PAD_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc      <= '0;
            slot_cnt <= '0;
            pending  <= 1'b0;
            out_data <= '0;
            blk_cnt  <= '0;
        end else begin
            if (out_wr_en)
                blk_cnt <= blk_cnt + {{(BLK_CNT_WIDTH-1){1'b0}}, 1'b1};

            if (close) begin
                out_data <= blk;
                pending  <= 1'b1;
                slot_cnt <= '0;
            end else begin
                if (out_wr_en)
                    pending <= 1'b0;
                if (accept) begin
                    case (slot_cnt)
                        2'd0:    acc[215:144] <= in_data;
                        2'd1:    acc[143:72]  <= in_data;
                        default: acc[71:0]    <= in_data;
                    endcase
                    slot_cnt <= slot_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr2_wr_blk_packer_72b_to_288b.sv
// Scoreboard bench: stimulus pushes hand-written expected blocks, a monitor checks each FIFO write.
module tb_ddr2_wr_blk_packer_72b_to_288b;

    localparam logic [71:0] PAD = 72'hFF;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [71:0]  in_data = '0;
    logic         in_eop = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [287:0] out_data;
    logic         out_wr_en;
    logic         out_full = 1'b0;
    logic [15:0]  blk_cnt;
    logic [1:0]   slot_cnt;

    logic         in_ready2;
    logic [287:0] out_data2;
    logic         out_wr_en2;
    logic [1:0]   blk_cnt2;
    logic [1:0]   slot_cnt2;

    int checks = 0;
    int fails  = 0;
    int stalls = 0;
    int exp_cnt = 0;
    logic [287:0] sb [$];

    always #5 clk = ~clk;

    ddr2_wr_blk_packer_72b_to_288b #(.PAD_WORD(PAD), .BLK_CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_eop(in_eop),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_wr_en(out_wr_en), .out_full(out_full), .blk_cnt(blk_cnt),
        .slot_cnt(slot_cnt)
    );

    // Narrow counter instance sharing all stimulus, used only for the wrap check.
    ddr2_wr_blk_packer_72b_to_288b #(.PAD_WORD(PAD), .BLK_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_eop(in_eop),
        .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
        .out_wr_en(out_wr_en2), .out_full(out_full), .blk_cnt(blk_cnt2),
        .slot_cnt(slot_cnt2)
    );

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] w(input logic [7:0] tag, input logic [7:0] idx);
        return {tag, 56'h0, idx};
    endfunction

    task automatic send(input logic [71:0] d, input logic e);
        logic acc;
        in_data  = d;
        in_eop   = e;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
            stalls++;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest expected block.
    initial begin
        forever begin
            @(negedge clk);
            if (out_wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", out_data, '0);
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: write with empty scoreboard");
                end else begin
                    chk("out_data", out_data, sb.pop_front());
                end
                @(posedge clk);
                #1;
                exp_cnt++;
                chk("blk_cnt", {272'd0, blk_cnt}, {272'd0, exp_cnt[15:0]});
                chk("blk_cnt_w2", {286'd0, blk_cnt2}, {286'd0, exp_cnt[1:0]});
            end
        end
    end

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {287'd0, in_ready}, 1);
        chk("rst_wr_en", {287'd0, out_wr_en}, 0);
        chk("rst_slot_cnt", {286'd0, slot_cnt}, 0);
        chk("rst_blk_cnt", {272'd0, blk_cnt}, 0);
        chk("rst_out_data", out_data, '0);
        reset_n = 1'b1;
        idle(1);

        // Four plain words form one block, written the cycle after the last word.
        sb.push_back({w(8'hA0, 0), w(8'hA0, 1), w(8'hA0, 2), w(8'hA0, 3)});
        send(w(8'hA0, 0), 0);
        send(w(8'hA0, 1), 0);
        chk("slot_cnt_2", {286'd0, slot_cnt}, 2);
        send(w(8'hA0, 2), 0);
        send(w(8'hA0, 3), 0);
        chk("latency_wr_en", {287'd0, out_wr_en}, 1);
        idle(3);

        // Single-word packet padded out.
        sb.push_back({72'h1, PAD, PAD, PAD});
        send(72'h1, 1);
        chk("eop_slot_cnt", {286'd0, slot_cnt}, 0);
        idle(3);

        // 3-word then 4-word packet back-to-back, no stalls.
        s0 = stalls;
        sb.push_back({w(8'hB0, 0), w(8'hB0, 1), w(8'hB0, 2), PAD});
        sb.push_back({w(8'hC0, 0), w(8'hC0, 1), w(8'hC0, 2), w(8'hC0, 3)});
        send(w(8'hB0, 0), 0);
        send(w(8'hB0, 1), 0);
        send(w(8'hB0, 2), 1);
        send(w(8'hC0, 0), 0);
        send(w(8'hC0, 1), 0);
        send(w(8'hC0, 2), 0);
        send(w(8'hC0, 3), 1);
        chk("b2b_no_stall", stalls - s0, 0);
        idle(3);

        // Backpressure: first block held while the FIFO is full, then both drain in order.
        sb.push_back({w(8'hD0, 0), w(8'hD0, 1), w(8'hD0, 2), w(8'hD0, 3)});
        sb.push_back({w(8'hD0, 4), w(8'hD0, 5), w(8'hD0, 6), w(8'hD0, 7)});
        out_full = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(w(8'hD0, 8'(i)), 0);
                idle(1);
            end
            begin
                repeat (6) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    chk("held_data", out_data, {w(8'hD0, 0), w(8'hD0, 1), w(8'hD0, 2), w(8'hD0, 3)});
                    chk("held_in_ready", {287'd0, in_ready}, 0);
                    chk("held_wr_en", {287'd0, out_wr_en}, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_full = 1'b0;
            end
        join
        idle(4);
        chk("bp_blk_cnt", {272'd0, blk_cnt}, 288'd6);

        // Reset with a pending block held by a full FIFO.
        out_full = 1'b1;
        send(w(8'hE0, 0), 1);
        idle(1);
        reset_n = 1'b0;
        exp_cnt = 0;
        idle(1);
        reset_n = 1'b1;
        out_full = 1'b0;
        idle(3);
        chk("rst_pend_slot_cnt", {286'd0, slot_cnt}, 0);
        chk("rst_pend_blk_cnt", {272'd0, blk_cnt}, 0);

        // Reset with a partial block in the accumulator.
        send(w(8'hE0, 1), 0);
        send(w(8'hE0, 2), 0);
        idle(0);
        chk("partial_slot_cnt", {286'd0, slot_cnt}, 2);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(2);
        chk("rst_part_slot_cnt", {286'd0, slot_cnt}, 0);

        sb.push_back({w(8'hF0, 0), w(8'hF0, 1), w(8'hF0, 2), w(8'hF0, 3)});
        for (int i = 0; i < 4; i++)
            send(w(8'hF0, 8'(i)), 0);
        idle(3);

        // Back-to-back single-word packets: one write per cycle, narrow counter wraps.
        s0 = stalls;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({w(8'h90, 8'(i)), PAD, PAD, PAD});
            send(w(8'h90, 8'(i)), 1);
        end
        chk("1w_no_stall", stalls - s0, 0);
        idle(3);

        for (int i = 0; i < 50 && sb.size() != 0; i++)
            @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("final_blk_cnt", {272'd0, blk_cnt}, 288'd5);
        chk("final_blk_cnt_w2", {286'd0, blk_cnt2}, 288'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
